// File: rtl/mmio_host_bridge.sv
// Host MMIO bridge: queues host command words toward the control unit and
// reports sticky completion status back to the host as paged 32-bit words.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   h2f_pio32, h2f_write  host word and its one-cycle write strobe
//   f2h_pio32, f2h_write  registered status page, new-completion pulse
//   cmd_data, cmd_valid   head-of-queue command word toward ctrl_unit
//   cmd_ready             ctrl_unit takes the head word
//   eu_done, fetch_done, cu_done, move_done, ldst_done  completion inputs
//
// Host words with [31:28]==4'hF are local ops (sub-op in [27:24]):
//   0 select page [7:0], 1 clear all status, 2 clear selected page,
//   3 flush queue, others ignored. All other words are queued commands.
module mmio_host_bridge #(
    parameter int EU_NUM    = 28,
    parameter int CMD_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       h2f_pio32,
    input  logic              h2f_write,
    output logic [31:0]       f2h_pio32,
    output logic              f2h_write,
    output logic [31:0]       cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic [EU_NUM-1:0] eu_done,
    input  logic              fetch_done,
    input  logic              cu_done,
    input  logic              move_done,
    input  logic              ldst_done
);

    localparam int EU_PAGES  = (EU_NUM > 28) ? (EU_NUM - 28 + 31) / 32 : 0;
    localparam int DIAG_PAGE = EU_PAGES + 1;
    // Status bits laid out exactly as the pages present them.
    localparam int SW        = 32 * (EU_PAGES + 1);
    localparam int AW        = $clog2(CMD_DEPTH);
    localparam int LW        = AW + 1;

    // Host word decode
    logic       w_local;
    logic       w_cmd;
    logic [3:0] w_op;
    logic       w_set_pg;
    logic       w_clr_all;
    logic       w_clr_pg;
    logic       w_flush;

    assign w_local   = h2f_write && (h2f_pio32[31:28] == 4'hF);
    assign w_cmd     = h2f_write && (h2f_pio32[31:28] != 4'hF);
    assign w_op      = h2f_pio32[27:24];
    assign w_set_pg  = w_local && (w_op == 4'h0);
    assign w_clr_all = w_local && (w_op == 4'h1);
    assign w_clr_pg  = w_local && (w_op == 4'h2);
    assign w_flush   = w_local && (w_op == 4'h3);

    // Command FIFO
    logic [31:0]   r_mem [CMD_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf;

    assign w_full  = (r_level == LW'(CMD_DEPTH));
    assign w_empty = (r_level == '0);
    // A flush swallows any pop offered in the same cycle.
    assign w_pop   = !w_empty && cmd_ready && !w_flush;
    // Full is fine as long as a slot frees up in the same cycle.
    assign w_push  = w_cmd && (!w_full || w_pop);
    assign w_ovf   = w_cmd && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= h2f_pio32;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    assign cmd_valid = !w_empty;
    assign cmd_data  = w_empty ? 32'h0 : r_mem[r_rptr];

    // Sticky completion bits
    logic [SW-1:0] r_sticky;
    logic [SW-1:0] w_done;
    logic [SW-1:0] w_clr;
    logic [7:0]    r_page_sel;

    always_comb begin
        w_done = '0;
        // EU bits above 27 skip the four unit bits that top page 0.
        for (int i = 0; i < EU_NUM; i++) begin
            w_done[(i < 28) ? i : i + 4] = eu_done[i];
        end
        w_done[28] = fetch_done;
        w_done[29] = cu_done;
        w_done[30] = ldst_done;
        w_done[31] = move_done;
    end

    always_comb begin
        w_clr = '0;
        if (w_clr_all) begin
            w_clr = '1;
        end else if (w_clr_pg) begin
            for (int p = 0; p <= EU_PAGES; p++) begin
                if (r_page_sel == 8'(p)) begin
                    w_clr[32*p +: 32] = '1;
                end
            end
        end
    end

    // Page read mux
    logic [31:0] w_page;

    always_comb begin
        w_page = 32'h0;
        for (int p = 0; p <= EU_PAGES; p++) begin
            if (r_page_sel == 8'(p)) begin
                w_page = r_sticky[32*p +: 32];
            end
        end
        if (r_page_sel == 8'(DIAG_PAGE)) begin
            w_page = {r_overflow, w_full, w_empty, 5'b0,
                      8'(r_level), 16'h0};
        end
    end

    logic [31:0] r_f2h_pio32;
    logic        r_f2h_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky    <= '0;
            r_overflow  <= 1'b0;
            r_page_sel  <= 8'h0;
            r_f2h_pio32 <= 32'h0;
            r_f2h_write <= 1'b0;
        end else begin
            // Set beats clear so a completion landing during a clear is kept.
            r_sticky    <= (r_sticky & ~w_clr) | w_done;
            r_f2h_write <= |(w_done & ~r_sticky);
            r_f2h_pio32 <= w_page;
            if (w_clr_all) begin
                r_overflow <= 1'b0;
            end else if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_set_pg) begin
                r_page_sel <= h2f_pio32[7:0];
            end
        end
    end

    assign f2h_pio32 = r_f2h_pio32;
    assign f2h_write = r_f2h_write;

endmodule

// File: tb/tb_mmio_host_bridge.sv
// Bench for mmio_host_bridge: command words are scoreboarded through a queue,
// status pages and notification pulses are checked against constants.
module tb_mmio_host_bridge;

    localparam int EU_NUM    = 64;
    localparam int CMD_DEPTH = 8;
    localparam int DIAG      = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       h2f_pio32;
    logic              h2f_write;
    logic [31:0]       f2h_pio32;
    logic              f2h_write;
    logic [31:0]       cmd_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [EU_NUM-1:0] eu_done;
    logic              fetch_done;
    logic              cu_done;
    logic              move_done;
    logic              ldst_done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    mmio_host_bridge #(
        .EU_NUM    (EU_NUM),
        .CMD_DEPTH (CMD_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .h2f_pio32  (h2f_pio32),
        .h2f_write  (h2f_write),
        .f2h_pio32  (f2h_pio32),
        .f2h_write  (f2h_write),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .eu_done    (eu_done),
        .fetch_done (fetch_done),
        .cu_done    (cu_done),
        .move_done  (move_done),
        .ldst_done  (ldst_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] word);
        h2f_pio32 = word;
        h2f_write = 1'b1;
        tick();
        h2f_write = 1'b0;
        h2f_pio32 = 32'h0;
    endtask

    task automatic cmd(input logic [31:0] word, input bit accepted);
        if (accepted) sb_q.push_back(word);
        wr(word);
    endtask

    task automatic page(input logic [7:0] p);
        wr(32'hF000_0000 | 32'(p));
        tick();
    endtask

    // Handshake monitor: every word handed to ctrl_unit must be the next one
    // the bench expects.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (!rst && cmd_valid && cmd_ready) begin
            e = (sb_q.size() != 0) ? sb_q.pop_front() : ~cmd_data;
            chk("cmd_data", cmd_data, e);
        end
    end

    initial begin
        rst        = 1'b1;
        h2f_pio32  = 32'h0;
        h2f_write  = 1'b0;
        cmd_ready  = 1'b0;
        eu_done    = '0;
        fetch_done = 1'b0;
        cu_done    = 1'b0;
        move_done  = 1'b0;
        ldst_done  = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_data", cmd_data, 32'h0);
        chk("rst_f2h", f2h_pio32, 32'h0);
        chk("rst_f2hw", 32'(f2h_write), 32'd0);
        rst = 1'b0;
        tick();

        // Basic queueing and hand-over
        cmd(32'h11, 1'b1);
        chk("first_valid", 32'(cmd_valid), 32'd1);
        chk("first_data", cmd_data, 32'h11);
        cmd(32'h12, 1'b1);
        cmd(32'h13, 1'b1);
        cmd_ready = 1'b1;
        repeat (3) tick();
        cmd_ready = 1'b0;
        chk("drain_valid", 32'(cmd_valid), 32'd0);
        chk("drain_sb", 32'(sb_q.size()), 32'd0);

        // Overflow on the ninth word
        for (int i = 0; i < 9; i++) begin
            cmd(32'h100 + 32'(i), i < CMD_DEPTH);
        end
        page(8'(DIAG));
        chk("diag_ovf", f2h_pio32, 32'hC008_0000);
        wr(32'hF100_0000);
        tick();
        chk("diag_clr", f2h_pio32, 32'h4008_0000);

        // Push and pop together while full
        cmd_ready = 1'b1;
        cmd(32'h200, 1'b1);
        cmd_ready = 1'b0;
        tick();
        chk("diag_pp", f2h_pio32, 32'h4008_0000);
        cmd_ready = 1'b1;
        repeat (8) tick();
        cmd_ready = 1'b0;
        chk("pp_sb", 32'(sb_q.size()), 32'd0);
        chk("pp_valid", 32'(cmd_valid), 32'd0);

        // Flush
        cmd(32'h301, 1'b0);
        cmd(32'h302, 1'b0);
        cmd(32'h303, 1'b0);
        wr(32'hF300_0000);
        chk("flush_valid", 32'(cmd_valid), 32'd0);
        tick();
        chk("flush_diag", f2h_pio32, 32'h2000_0000);

        // Page 0 sticky bits and notification pulses
        page(8'd0);
        chk("pg0_empty", f2h_pio32, 32'h0);
        eu_done[3] = 1'b1;
        cu_done    = 1'b1;
        tick();
        eu_done = '0;
        cu_done = 1'b0;
        chk("pulse_1", 32'(f2h_write), 32'd1);
        tick();
        chk("pulse_once", 32'(f2h_write), 32'd0);
        chk("pg0_a", f2h_pio32, 32'h2000_0008);
        eu_done[3] = 1'b1;
        tick();
        eu_done = '0;
        chk("no_repulse", 32'(f2h_write), 32'd0);
        eu_done[1] = 1'b1;
        tick();
        chk("cont_1", 32'(f2h_write), 32'd1);
        eu_done    = '0;
        eu_done[2] = 1'b1;
        tick();
        chk("cont_2", 32'(f2h_write), 32'd1);
        eu_done    = '0;
        fetch_done = 1'b1;
        ldst_done  = 1'b1;
        move_done  = 1'b1;
        tick();
        chk("cont_3", 32'(f2h_write), 32'd1);
        fetch_done = 1'b0;
        ldst_done  = 1'b0;
        move_done  = 1'b0;
        tick();
        chk("cont_end", 32'(f2h_write), 32'd0);
        chk("pg0_b", f2h_pio32, 32'hF000_000E);
        wr(32'hF100_0000);
        tick();
        chk("clr_all", f2h_pio32, 32'h0);

        // Upper EU pages
        eu_done[40] = 1'b1;
        eu_done[63] = 1'b1;
        tick();
        eu_done = '0;
        chk("eu_pulse", 32'(f2h_write), 32'd1);
        page(8'd1);
        chk("pg1", f2h_pio32, 32'h0000_1000);
        page(8'd2);
        chk("pg2", f2h_pio32, 32'h0000_0008);
        wr(32'hF200_0000);
        tick();
        chk("pg2_clr", f2h_pio32, 32'h0);
        page(8'd1);
        chk("pg1_kept", f2h_pio32, 32'h0000_1000);
        page(8'd9);
        chk("pg9", f2h_pio32, 32'h0);
        page(8'(DIAG));
        chk("diag_idle", f2h_pio32, 32'h2000_0000);

        // Set wins over page clear
        page(8'd0);
        chk("pg0_clean", f2h_pio32, 32'h0);
        eu_done[0] = 1'b1;
        tick();
        wr(32'hF200_0000);
        chk("held_nopulse", 32'(f2h_write), 32'd0);
        eu_done = '0;
        tick();
        chk("held_set", f2h_pio32, 32'h0000_0001);
        wr(32'hF200_0000);
        tick();
        chk("pg_clr", f2h_pio32, 32'h0);

        // Reset in the middle of a burst
        eu_done[5] = 1'b1;
        tick();
        eu_done = '0;
        for (int i = 0; i < 5; i++) begin
            cmd(32'h501 + 32'(i), 1'b0);
        end
        chk("pre_rst_f2h", f2h_pio32, 32'h0000_0020);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
        chk("mid_rst_data", cmd_data, 32'h0);
        chk("mid_rst_f2h", f2h_pio32, 32'h0);
        cmd(32'h600, 1'b1);
        chk("post_rst_data", cmd_data, 32'h600);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("post_rst_sb", 32'(sb_q.size()), 32'd0);
        chk("post_rst_valid", 32'(cmd_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
